vrf_rd_arb: RTL and testbench

Vector-register-file read-port arbiter for the vector unit's execution side. It shares the single VRF source-operand read port among the functional units (alu, mac, ld, st, msk, sld) using round-robin arbitration. Each granted register-group read is sequenced beat by beat. When the group's last source register has been read, the block reports completion to the dispatch-stage scoreboard on its fu_resp_vs_wr/fu_resp_vs_id inputs, which releases WAR hazards.

---
 rtl/vrf_rd_arb.sv | 165 ++++++++++++++++
 tb/tb_vrf_rd_arb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_rd_arb.sv
// vrf_rd_arb
// Round-robin arbiter for the single VRF source-operand read port.
// Requesters (0 alu, 1 mac, 2 ld, 3 st, 4 msk, 5 sld) post a register-group
// read. The winner's group is issued one register per cycle. The read is
// counted modulo 32 from the group's first source register. On the last beat
// the owner gets a completion pulse and the scoreboard gets a source-done pulse.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   fu_rd_req_valid     per-requester group read pending
//   fu_rd_req_ready     per-requester one-cycle completion pulse
//   fu_rd_req_id        per-requester scoreboard id (ID_W bits each, flattened)
//   fu_rd_req_vs        per-requester first source register (5 bits each)
//   fu_rd_req_nm1       per-requester beats minus one (3 bits each)
//   vrf_rd_stall        port unavailable this cycle
//   vrf_rd_en/addr      read beat valid / register address
//   vrf_rd_owner        one-hot owner of the beat
//   vrf_rd_last         beat is the last of its group
//   fu_resp_vs_wr/id    source-read-done pulse and id, per requester
module vrf_rd_arb #(
    parameter int FU_NUM = 6,
    parameter int ID_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FU_NUM-1:0]        fu_rd_req_valid,
    output logic [FU_NUM-1:0]        fu_rd_req_ready,
    input  logic [FU_NUM*ID_W-1:0]   fu_rd_req_id,
    input  logic [FU_NUM*5-1:0]      fu_rd_req_vs,
    input  logic [FU_NUM*3-1:0]      fu_rd_req_nm1,
    input  logic                     vrf_rd_stall,
    output logic                     vrf_rd_en,
    output logic [4:0]               vrf_rd_addr,
    output logic [FU_NUM-1:0]        vrf_rd_owner,
    output logic                     vrf_rd_last,
    output logic [FU_NUM-1:0]        fu_resp_vs_wr,
    output logic [FU_NUM*ID_W-1:0]   fu_resp_vs_id
);

    localparam int IDX_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [4:0]        r_base;
    logic [2:0]        r_nm1;
    logic [ID_W-1:0]   r_id;
    logic [2:0]        r_beat;

    logic [IDX_W-1:0]  w_win;
    logic              w_win_found;
    logic [4:0]        w_win_vs;
    logic [2:0]        w_win_nm1;
    logic [ID_W-1:0]   w_win_id;
    logic [IDX_W-1:0]  w_owner_inc;
    logic              w_beat_go;
    logic              w_last_go;

    // Search from rr_ptr upward with wrap. The loop runs from the farthest
    // offset down so the nearest valid requester is the final assignment.
    always_comb begin
        int idx;
        idx         = 0;
        w_win       = '0;
        w_win_found = 1'b0;
        for (int k = FU_NUM - 1; k >= 0; k--) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= FU_NUM) idx = idx - FU_NUM;
            if (fu_rd_req_valid[idx]) begin
                w_win       = IDX_W'(idx);
                w_win_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_win_vs  = '0;
        w_win_nm1 = '0;
        w_win_id  = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            if (w_win == IDX_W'(i)) begin
                w_win_vs  = fu_rd_req_vs[i*5 +: 5];
                w_win_nm1 = fu_rd_req_nm1[i*3 +: 3];
                w_win_id  = fu_rd_req_id[i*ID_W +: ID_W];
            end
        end
    end

    assign w_owner_inc = (r_owner == IDX_W'(FU_NUM - 1)) ? '0 : r_owner + 1'b1;
    assign w_beat_go   = (r_state == S_BURST) && !vrf_rd_stall;
    assign w_last_go   = w_beat_go && (r_beat == r_nm1);

    // Next state and outputs. Outputs depend only on registered state and the
    // stall input, never on the request inputs.
    always_comb begin
        w_state_nxt     = r_state;
        vrf_rd_en       = 1'b0;
        vrf_rd_addr     = '0;
        vrf_rd_owner    = '0;
        vrf_rd_last     = 1'b0;
        fu_rd_req_ready = '0;
        fu_resp_vs_wr   = '0;
        fu_resp_vs_id   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_win_found) w_state_nxt = S_BURST;
            end
            S_BURST: begin
                if (w_beat_go) begin
                    vrf_rd_en   = 1'b1;
                    // 5-bit sum wraps naturally past v31
                    vrf_rd_addr = r_base + {2'b00, r_beat};
                    vrf_rd_last = w_last_go;
                    if (w_last_go) w_state_nxt = S_IDLE;
                    for (int i = 0; i < FU_NUM; i++) begin
                        if (r_owner == IDX_W'(i)) begin
                            vrf_rd_owner[i]    = 1'b1;
                            fu_rd_req_ready[i] = w_last_go;
                            fu_resp_vs_wr[i]   = w_last_go;
                            if (w_last_go) fu_resp_vs_id[i*ID_W +: ID_W] = r_id;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_base   <= '0;
            r_nm1    <= '0;
            r_id     <= '0;
            r_beat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_win_found) begin
                r_owner <= w_win;
                r_base  <= w_win_vs;
                r_nm1   <= w_win_nm1;
                r_id    <= w_win_id;
                r_beat  <= '0;
            end
            if (w_beat_go) begin
                if (w_last_go) begin
                    // Pointer moves only at completion, so no preemption
                    r_rr_ptr <= w_owner_inc;
                    r_beat   <= '0;
                end else begin
                    r_beat <= r_beat + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vrf_rd_arb.sv
// Randomized bench for vrf_rd_arb. The reference model holds the granted group
// as a queue of pending register addresses and pops one per unstalled cycle.
module tb_vrf_rd_arb;

    localparam int FU = 6;
    localparam int IW = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [FU-1:0]      valid;
    logic [FU-1:0]      ready;
    logic [FU*IW-1:0]   id_in;
    logic [FU*5-1:0]    vs_in;
    logic [FU*3-1:0]    nm1_in;
    logic               stall;
    logic               rd_en;
    logic [4:0]         rd_addr;
    logic [FU-1:0]      rd_owner;
    logic               rd_last;
    logic [FU-1:0]      resp_wr;
    logic [FU*IW-1:0]   resp_id;

    always #5 clk = ~clk;

    vrf_rd_arb #(.FU_NUM(FU), .ID_W(IW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fu_rd_req_valid (valid),
        .fu_rd_req_ready (ready),
        .fu_rd_req_id    (id_in),
        .fu_rd_req_vs    (vs_in),
        .fu_rd_req_nm1   (nm1_in),
        .vrf_rd_stall    (stall),
        .vrf_rd_en       (rd_en),
        .vrf_rd_addr     (rd_addr),
        .vrf_rd_owner    (rd_owner),
        .vrf_rd_last     (rd_last),
        .fu_resp_vs_wr   (resp_wr),
        .fu_resp_vs_id   (resp_id)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // requester state
    int rq_v[FU];
    int rq_vs[FU];
    int rq_n[FU];
    int rq_id[FU];
    int rq_done[FU];

    // reference model state
    int q_addr[$];
    int m_owner = 0;
    int m_id    = 0;
    int m_rr    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"},    32'(rd_en),    32'd0);
        chk({tag, "_addr"},  32'(rd_addr),  32'd0);
        chk({tag, "_owner"}, 32'(rd_owner), 32'd0);
        chk({tag, "_last"},  32'(rd_last),  32'd0);
        chk({tag, "_ready"}, 32'(ready),    32'd0);
        chk({tag, "_wr"},    32'(resp_wr),  32'd0);
        chk({tag, "_id"},    32'(resp_id),  32'd0);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < FU; i++) begin
            valid[i]            = (rq_v[i] != 0);
            vs_in[i*5 +: 5]     = 5'(rq_vs[i]);
            nm1_in[i*3 +: 3]    = 3'(rq_n[i]);
            id_in[i*IW +: IW]   = IW'(rq_id[i]);
        end
    endtask

    task automatic new_req(input int i, input int maxn);
        rq_v[i]  = 1;
        rq_vs[i] = int'($urandom_range(0, 31));
        rq_n[i]  = int'($urandom_range(0, maxn));
        rq_id[i] = int'($urandom_range(0, (1 << IW) - 1));
    endtask

    // Compare this cycle's outputs with the model, then advance the model
    // across the coming rising edge.
    task automatic check_and_step();
        logic              e_en;
        logic [4:0]        e_addr;
        logic [FU-1:0]     e_own;
        logic              e_last;
        logic [FU-1:0]     e_rdy;
        logic [FU*IW-1:0]  e_id;
        #1;
        e_en = 1'b0; e_addr = '0; e_own = '0; e_last = 1'b0; e_rdy = '0; e_id = '0;
        if (q_addr.size() > 0 && !stall) begin
            e_en   = 1'b1;
            e_addr = 5'(q_addr[0]);
            e_own  = FU'(1) << m_owner;
            if (q_addr.size() == 1) begin
                e_last = 1'b1;
                e_rdy  = FU'(1) << m_owner;
                e_id[m_owner*IW +: IW] = IW'(m_id);
            end
        end
        chk("rd_en",    32'(rd_en),    32'(e_en));
        chk("rd_addr",  32'(rd_addr),  32'(e_addr));
        chk("rd_owner", 32'(rd_owner), 32'(e_own));
        chk("rd_last",  32'(rd_last),  32'(e_last));
        chk("ready",    32'(ready),    32'(e_rdy));
        chk("resp_wr",  32'(resp_wr),  32'(e_rdy));
        chk("resp_id",  32'(resp_id),  32'(e_id));

        if (q_addr.size() > 0) begin
            if (!stall) begin
                void'(q_addr.pop_front());
                if (q_addr.size() == 0) begin
                    m_rr = (m_owner + 1) % FU;
                    rq_done[m_owner] = 1;
                end
            end
        end else begin
            for (int k = 0; k < FU; k++) begin
                int j;
                j = (m_rr + k) % FU;
                if (rq_v[j] != 0) begin
                    for (int b = 0; b <= rq_n[j]; b++) q_addr.push_back((rq_vs[j] + b) % 32);
                    m_owner = j;
                    m_id    = rq_id[j];
                    break;
                end
            end
        end
    endtask

    task automatic cycle(input int density, input int stallpct, input int maxn);
        @(negedge clk);
        for (int i = 0; i < FU; i++) begin
            if (rq_done[i] != 0) begin
                rq_done[i] = 0;
                if (int'($urandom_range(0, 99)) < density) new_req(i, maxn);
                else rq_v[i] = 0;
            end else if (rq_v[i] == 0 && int'($urandom_range(0, 99)) < density) begin
                new_req(i, maxn);
            end
        end
        stall = (int'($urandom_range(0, 99)) < stallpct);
        drive_inputs();
        check_and_step();
    endtask

    initial begin
        int g;
        rst_n = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < FU; i++) begin
            rq_v[i] = 0; rq_vs[i] = 0; rq_n[i] = 0; rq_id[i] = 0; rq_done[i] = 0;
        end
        drive_inputs();
        #2;
        chk_zero("rst_early");
        valid = '1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst_hold");
        valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // mixed traffic, moderate stall
        repeat (400) cycle(40, 20, 7);
        // everyone busy with single-beat groups: strict rotation, one bubble
        repeat (60) cycle(100, 0, 0);
        // heavy traffic, short groups, frequent stall
        repeat (300) cycle(80, 30, 3);

        // drain to idle with no requesters left
        g = 0;
        while ((q_addr.size() != 0 || rq_v[0] != 0 || rq_v[1] != 0 || rq_v[2] != 0 ||
                rq_v[3] != 0 || rq_v[4] != 0 || rq_v[5] != 0) && g < 300) begin
            cycle(0, 0, 7);
            g++;
        end
        chk("drain_timeout", 32'(g < 300), 32'd1);

        // 8-beat ld group, reset during its third beat
        rq_v[2] = 1; rq_vs[2] = 3; rq_n[2] = 7; rq_id[2] = 6;
        cycle(0, 0, 7);
        cycle(0, 0, 7);
        cycle(0, 0, 7);
        @(negedge clk);
        stall = 1'b0;
        drive_inputs();
        #1;
        chk("pre_rst_addr",  32'(rd_addr),  32'd5);
        chk("pre_rst_owner", 32'(rd_owner), 32'b000100);
        rst_n   = 1'b0;
        rq_v[2] = 0;
        drive_inputs();
        #1;
        chk_zero("rst_mid");
        q_addr.delete();
        m_rr = 0;
        for (int i = 0; i < FU; i++) rq_done[i] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) cycle(0, 0, 7);

        // traffic again after reset: rotation restarts from alu
        repeat (300) cycle(60, 25, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
